uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Byte-level command controller sitting directly downstream of the UART receiver and upstream of the UART transmitter. Assembles received bytes into read/write/ping command frames, performs one access on a simple synchronous register bus, and returns a one-byte response through the UART transmit handshake. Includes an inter-byte timeout so a truncated frame never wedges the parser.

## Interface
- `TIMEOUT_CYCLES`, default 500000: idle clocks allowed between bytes of one frame (10 ms at 50 MHz).
- `clk` in 1: system clock, 50 MHz.
- `nRst` in 1: reset, synchronous, active-low.
- `rx_valid` in 1: one-cycle pulse, `rx_data` holds a new received byte.
- `rx_data` in 8: received byte.
- `tx_busy` in 1: UART transmitter busy.
- `tx_start` out 1: one-cycle pulse requesting transmission of `tx_data`.
- `tx_data` out 8: byte to transmit, held stable from `tx_start` until the next `tx_start`.
- `reg_addr` out 8: register bus address.
- `reg_wdata` out 8: register bus write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid exactly one cycle after `reg_re`.
- `err_overrun` out 1: sticky; byte arrived while not accepting. Cleared only by reset.

## Operation
- Opcodes: 0x01 WRITE (opcode, addr, data), 0x02 READ (opcode, addr), 0x03 PING (opcode only). Any other first byte is UNKNOWN.
- Responses: WRITE -> 0xA5; READ -> `reg_rdata`; PING -> 0x5A; UNKNOWN -> 0xEE.
- States:
  - IDLE: on `rx_valid`, latch opcode. 0x01/0x02 -> GET_ADDR. 0x03/unknown -> SEND with the response loaded.
  - GET_ADDR: on `rx_valid`, latch `reg_addr`. WRITE -> GET_DATA. READ -> EXEC.
  - GET_DATA: on `rx_valid`, latch `reg_wdata` -> EXEC.
  - EXEC: one cycle. WRITE pulses `reg_we` and loads 0xA5 -> SEND. READ pulses `reg_re` -> READ_WAIT.
  - READ_WAIT: one cycle. Capture `reg_rdata` into `tx_data` -> SEND.
  - SEND: wait while `tx_busy`=1. When `tx_busy`=0, pulse `tx_start` -> HOLD.
  - HOLD: one cycle, `tx_busy` ignored while the UART registers the request -> IDLE.
- Byte acceptance:
  - Accepted only in IDLE, GET_ADDR and GET_DATA.
  - `rx_valid` in EXEC, READ_WAIT, SEND or HOLD drops the byte and sets `err_overrun`.
- Timeout:
  - Counter counts clocks in GET_ADDR/GET_DATA and clears on every accepted byte and on leaving these states.
  - When the count reaches `TIMEOUT_CYCLES-1` with no `rx_valid` that cycle -> IDLE, no response, no bus access.
  - `rx_valid` in the same cycle as expiry wins: the byte is accepted.
  - Counter width is clog2(`TIMEOUT_CYCLES`). It saturates and never wraps.

## Timing
- Reset values, and the values after reset mid-frame or mid-send: state IDLE; `tx_start`, `reg_we`, `reg_re`, `err_overrun` = 0; `tx_data`, `reg_addr`, `reg_wdata` = 0x00; timeout counter 0.
- Reset aborts any partial frame. No response is emitted.
- Latency, last byte `rx_valid` at cycle N:
  - WRITE: `reg_we` at N+1; `tx_start` at N+2 if `tx_busy`=0.
  - READ: `reg_re` at N+1; `tx_start` at N+3 if `tx_busy`=0.
  - PING/UNKNOWN: `tx_start` at N+1 if `tx_busy`=0.
- `tx_busy` stalls only the SEND state; stall length is unbounded.
- All outputs are registered.
- `reg_addr` and `reg_wdata` hold their values until the next frame overwrites them.

## Structure
- Package `uart_cmd_pkg`: opcode constants (OP_WRITE, OP_READ, OP_PING), response constants (RSP_ACK, RSP_PONG, RSP_ERR), state enum.
- Sub-module `uart_cmd_timeout`: parameterised saturating counter with clear/enable inputs and an expire output.
- Everything else lives in `uart_cmd_ctrl`.

## Test plan
- Write then read: rx 0x01,0x10,0x3C. Expect `reg_we` with addr 0x10, wdata 0x3C, then tx 0xA5. Then rx 0x02,0x10 with bus model returning 0x3C: expect `reg_re` on addr 0x10, then tx 0x3C.
- PING and unknown: rx 0x03 -> tx 0x5A. rx 0x7F -> tx 0xEE. No bus strobes in either case.
- Timeout: rx 0x01,0x20, then silence for `TIMEOUT_CYCLES` clocks (bench sets 16). Expect return to IDLE with no tx and no `reg_we`. Next rx 0x03 -> tx 0x5A.
- Expiry race: second byte pulsed exactly on the expiry cycle. Expect it accepted and the frame completed.
- Back-pressure and overrun: hold `tx_busy`=1 for 100 cycles during PING. Expect `tx_start` one cycle after `tx_busy` falls. A byte injected during the stall sets `err_overrun`=1 and is not parsed.
- Reset mid-frame: rx 0x01,0x10, drop `nRst` for one cycle. Expect all outputs at reset values. Then rx 0x03 -> tx 0x5A.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command controller.
//   Opcodes     : OP_WRITE, OP_READ, OP_PING
//   Responses   : RSP_ACK, RSP_PONG, RSP_ERR
//   FSM states  : state_t
package uart_cmd_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] OP_WRITE = 8'h01;
   localparam logic [BYTE_W-1:0] OP_READ  = 8'h02;
   localparam logic [BYTE_W-1:0] OP_PING  = 8'h03;

   localparam logic [BYTE_W-1:0] RSP_ACK  = 8'hA5;
   localparam logic [BYTE_W-1:0] RSP_PONG = 8'h5A;
   localparam logic [BYTE_W-1:0] RSP_ERR  = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GET_ADDR  = 3'd1,
      ST_GET_DATA  = 3'd2,
      ST_EXEC      = 3'd3,
      ST_READ_WAIT = 3'd4,
      ST_SEND      = 3'd5,
      ST_HOLD      = 3'd6
   } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Saturating inter-byte timeout counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the count (takes priority over en)
//   en         : count one clock
//   expire_c   : combinational, high while enabled and the count sits at TIMEOUT_CYCLES-1
module uart_cmd_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Count up to CNT_MAX and stick there; never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expire_c = en && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-level command controller between UART RX/TX and a register bus.
// Parses WRITE(01 addr data) / READ(02 addr) / PING(03) frames, does one bus
// access and answers with a single byte.
//   clk, nRst          : clock, synchronous active-low reset
//   rx_valid, rx_data  : received byte strobe and value
//   tx_busy            : transmitter busy
//   tx_start, tx_data  : transmit request pulse and byte
//   reg_addr/wdata/we/re, reg_rdata : register bus (rdata one cycle after re)
//   err_overrun        : sticky, byte dropped while not accepting
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [BYTE_W-1:0] tx_data,
   output logic [BYTE_W-1:0] reg_addr,
   output logic [BYTE_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [BYTE_W-1:0] reg_rdata,
   output logic              err_overrun
);

   state_t            state, state_nxt;
   logic [BYTE_W-1:0] op, op_nxt;
   logic [BYTE_W-1:0] rsp, rsp_nxt;
   logic [BYTE_W-1:0] tx_data_nxt, addr_nxt, wdata_nxt;
   logic              tx_start_nxt, we_nxt, re_nxt, overrun_nxt;

   logic              go_send;
   logic [BYTE_W-1:0] rsp_val;
   logic              tmo_clr, tmo_en, tmo_expire_c;

   uart_cmd_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (nRst),
      .clr      (tmo_clr),
      .en       (tmo_en),
      .expire_c (tmo_expire_c)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         state       <= ST_IDLE;
         op          <= '0;
         rsp         <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         reg_addr    <= '0;
         reg_wdata   <= '0;
         reg_we      <= 1'b0;
         reg_re      <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state       <= state_nxt;
         op          <= op_nxt;
         rsp         <= rsp_nxt;
         tx_start    <= tx_start_nxt;
         tx_data     <= tx_data_nxt;
         reg_addr    <= addr_nxt;
         reg_wdata   <= wdata_nxt;
         reg_we      <= we_nxt;
         reg_re      <= re_nxt;
         err_overrun <= overrun_nxt;
      end
   end

   // Next-state and next-output logic. Strobes are computed one state early so
   // the registered pulse lines up with the cycle the FSM is in EXEC / HOLD.
   always_comb begin
      state_nxt    = state;
      op_nxt       = op;
      rsp_nxt      = rsp;
      tx_start_nxt = 1'b0;
      tx_data_nxt  = tx_data;
      addr_nxt     = reg_addr;
      wdata_nxt    = reg_wdata;
      we_nxt       = 1'b0;
      re_nxt       = 1'b0;
      overrun_nxt  = err_overrun;
      go_send      = 1'b0;
      rsp_val      = '0;
      tmo_en       = 1'b0;
      tmo_clr      = 1'b1;

      case (state)
         ST_IDLE: begin
            if (rx_valid) begin
               op_nxt = rx_data;
               case (rx_data)
                  OP_WRITE, OP_READ: state_nxt = ST_GET_ADDR;
                  OP_PING: begin
                     go_send = 1'b1;
                     rsp_val = RSP_PONG;
                  end
                  default: begin
                     go_send = 1'b1;
                     rsp_val = RSP_ERR;
                  end
               endcase
            end
         end
         ST_GET_ADDR: begin
            tmo_en = 1'b1;
            if (rx_valid) begin
               addr_nxt = rx_data;
               if (op == OP_WRITE) begin
                  state_nxt = ST_GET_DATA;
               end else begin
                  re_nxt    = 1'b1;
                  state_nxt = ST_EXEC;
               end
            end else if (tmo_expire_c) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_GET_DATA: begin
            tmo_en = 1'b1;
            if (rx_valid) begin
               wdata_nxt = rx_data;
               we_nxt    = 1'b1;
               state_nxt = ST_EXEC;
            end else if (tmo_expire_c) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (op == OP_WRITE) begin
               go_send = 1'b1;
               rsp_val = RSP_ACK;
            end else begin
               state_nxt = ST_READ_WAIT;
            end
         end
         ST_READ_WAIT: begin
            go_send = 1'b1;
            rsp_val = reg_rdata;
         end
         ST_SEND: begin
            if (!tx_busy) begin
               tx_start_nxt = 1'b1;
               tx_data_nxt  = rsp;
               state_nxt    = ST_HOLD;
            end
         end
         ST_HOLD: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase

      // Fire immediately when the transmitter is free, otherwise park in SEND.
      // tx_data only changes together with tx_start.
      if (go_send) begin
         if (!tx_busy) begin
            tx_start_nxt = 1'b1;
            tx_data_nxt  = rsp_val;
            state_nxt    = ST_HOLD;
         end else begin
            rsp_nxt   = rsp_val;
            state_nxt = ST_SEND;
         end
      end

      // Bytes outside the parsing states are dropped and flagged.
      if (rx_valid && (state inside {ST_EXEC, ST_READ_WAIT, ST_SEND, ST_HOLD})) begin
         overrun_nxt = 1'b1;
      end

      // Restart the timeout on every accepted byte and whenever parsing stops.
      tmo_clr = rx_valid || !(state_nxt inside {ST_GET_ADDR, ST_GET_DATA});
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl (TIMEOUT_CYCLES = 16).
module tb_uart_cmd_ctrl;

   localparam int unsigned TMO = 16;

   logic       clk = 1'b0;
   logic       nRst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       err_overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int n_we    = 0;
   int n_re    = 0;
   int n_tx    = 0;
   int snap_we, snap_re, snap_tx;

   logic [7:0] mem [256];

   always #5 clk = ~clk;

   uart_cmd_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .nRst        (nRst),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_we      (reg_we),
      .reg_re      (reg_re),
      .reg_rdata   (reg_rdata),
      .err_overrun (err_overrun)
   );

   // Register bus model: read data valid only in the cycle after reg_re.
   always @(posedge clk) begin
      if (reg_we) mem[reg_addr] <= reg_wdata;
      reg_rdata <= reg_re ? mem[reg_addr] : 8'h00;
   end

   // Strobe counters.
   always @(negedge clk) begin
      if (reg_we)   n_we <= n_we + 1;
      if (reg_re)   n_re <= n_re + 1;
      if (tx_start) n_tx <= n_tx + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_start"}, 32'(tx_start),    32'h0);
      check({tag, "_tx_data"},  32'(tx_data),     32'h00);
      check({tag, "_addr"},     32'(reg_addr),    32'h00);
      check({tag, "_wdata"},    32'(reg_wdata),   32'h00);
      check({tag, "_we"},       32'(reg_we),      32'h0);
      check({tag, "_re"},       32'(reg_re),      32'h0);
      check({tag, "_overrun"},  32'(err_overrun), 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      nRst     = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_busy  = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      nRst = 1'b1;
      repeat (2) tick();

      // WRITE 0x3C to 0x10: reg_we at N+1, ack at N+2.
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h3C);
      check("wr_we",    32'(reg_we),    32'h1);
      check("wr_addr",  32'(reg_addr),  32'h10);
      check("wr_wdata", 32'(reg_wdata), 32'h3C);
      check("wr_tx_early", 32'(tx_start), 32'h0);
      tick();
      check("wr_we_pulse", 32'(reg_we),   32'h0);
      check("wr_tx",       32'(tx_start), 32'h1);
      check("wr_tx_data",  32'(tx_data),  32'hA5);
      repeat (2) tick();

      // READ 0x10: reg_re at N+1, response at N+3.
      send_byte(8'h02);
      send_byte(8'h10);
      check("rd_re",   32'(reg_re),   32'h1);
      check("rd_addr", 32'(reg_addr), 32'h10);
      tick();
      check("rd_re_pulse", 32'(reg_re),   32'h0);
      check("rd_tx_early", 32'(tx_start), 32'h0);
      tick();
      check("rd_tx",      32'(tx_start), 32'h1);
      check("rd_tx_data", 32'(tx_data),  32'h3C);
      tick();
      check("rd_tx_pulse", 32'(tx_start), 32'h0);
      check("rd_tx_hold",  32'(tx_data),  32'h3C);
      tick();

      // PING and UNKNOWN: answer at N+1, no bus strobes.
      snap_we = n_we;
      snap_re = n_re;
      send_byte(8'h03);
      check("ping_tx",      32'(tx_start), 32'h1);
      check("ping_tx_data", 32'(tx_data),  32'h5A);
      repeat (2) tick();
      send_byte(8'h7F);
      check("unk_tx",      32'(tx_start), 32'h1);
      check("unk_tx_data", 32'(tx_data),  32'hEE);
      repeat (2) tick();
      check("ping_unk_no_we", 32'(n_we), 32'(snap_we));
      check("ping_unk_no_re", 32'(n_re), 32'(snap_re));

      // Timeout: silence for TMO clocks after the address byte aborts the frame.
      snap_we = n_we;
      snap_tx = n_tx;
      send_byte(8'h01);
      send_byte(8'h20);
      repeat (TMO) tick();
      check("tmo_no_tx", 32'(n_tx), 32'(snap_tx));
      send_byte(8'h03);
      check("tmo_ping_tx",      32'(tx_start), 32'h1);
      check("tmo_ping_tx_data", 32'(tx_data),  32'h5A);
      repeat (2) tick();
      check("tmo_no_we", 32'(n_we), 32'(snap_we));

      // Expiry race: data byte arrives exactly on the expiry cycle.
      send_byte(8'h01);
      send_byte(8'h20);
      repeat (TMO - 1) tick();
      send_byte(8'h55);
      check("race_we",    32'(reg_we),    32'h1);
      check("race_addr",  32'(reg_addr),  32'h20);
      check("race_wdata", 32'(reg_wdata), 32'h55);
      tick();
      check("race_tx",      32'(tx_start), 32'h1);
      check("race_tx_data", 32'(tx_data),  32'hA5);
      repeat (2) tick();

      // Back-pressure with an overrun byte injected mid-stall.
      check("ovr_clear", 32'(err_overrun), 32'h0);
      snap_tx = n_tx;
      tx_busy = 1'b1;
      send_byte(8'h03);
      check("bp_stall", 32'(tx_start), 32'h0);
      repeat (49) tick();
      send_byte(8'h01);
      check("bp_overrun", 32'(err_overrun), 32'h1);
      repeat (49) tick();
      check("bp_no_tx", 32'(n_tx), 32'(snap_tx));
      tx_busy = 1'b0;
      tick();
      check("bp_tx",      32'(tx_start), 32'h1);
      check("bp_tx_data", 32'(tx_data),  32'h5A);
      repeat (2) tick();
      send_byte(8'h03);
      check("bp_dropped_tx",   32'(tx_start),    32'h1);
      check("bp_dropped_data", 32'(tx_data),     32'h5A);
      check("bp_sticky",       32'(err_overrun), 32'h1);
      repeat (2) tick();

      // Reset mid-frame clears everything, then a PING still works.
      snap_we = n_we;
      send_byte(8'h01);
      send_byte(8'h10);
      nRst = 1'b0;
      tick();
      check_reset_outputs("midrst");
      nRst = 1'b1;
      tick();
      send_byte(8'h03);
      check("midrst_ping_tx",   32'(tx_start), 32'h1);
      check("midrst_ping_data", 32'(tx_data),  32'h5A);
      repeat (2) tick();
      check("midrst_no_we", 32'(n_we), 32'(snap_we));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
